error_scheduler: RTL

Time-multiplexes one shared one-cycle error subtractor (result = a − b, registered, valid one cycle after enable) across NUM_CH control channels. Each channel presents a measurement sample; the block pairs it with that channel's programmed setpoint, issues the pair to the subtractor, and returns the error tagged with its channel number. It sits between the per-channel sensor front ends and the downstream PID cells, and owns the setpoint register file.

---
 rtl/error_scheduler_pkg.sv | 17 +
 rtl/error_rr_arbiter.sv | 33 +++
 rtl/error_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/error_scheduler_pkg.sv
// Shared definitions for the error scheduler: FSM encoding and a width helper.
package error_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Smallest r with 2**r >= n; used to validate the channel index width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/error_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant_i+1, wrapping.
module error_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_grant_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [CH_W-1:0]   idx_o
);

  // Walk the channels starting just after the previous winner; first requester wins.
  always_comb begin
    int c;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    if (en_i) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        c = (int'(last_grant_i) + i) % NUM_CH;
        if (!found && req_i[CH_W'(c)]) begin
          found                = 1'b1;
          grant_o[CH_W'(c)]    = 1'b1;
          idx_o                = CH_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/error_scheduler.sv
// Shares one external registered subtractor among NUM_CH channels and owns
// the setpoint register file. One transaction at a time: grant, issue, wait
// for the result, hold it until the downstream accepts.
module error_scheduler
  import error_scheduler_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [CH_W-1:0]            cfg_ch,
  input  logic [NUM_BITS-1:0]        cfg_data,
  input  logic [NUM_CH-1:0]          meas_valid,
  input  logic [NUM_CH*NUM_BITS-1:0] meas_data,
  output logic [NUM_CH-1:0]          meas_ready,
  output logic                       sub_en,
  output logic [NUM_BITS-1:0]        sub_a,
  output logic [NUM_BITS-1:0]        sub_b,
  input  logic                       sub_valid,
  input  logic [NUM_BITS-1:0]        sub_result,
  output logic                       err_valid,
  output logic [CH_W-1:0]            err_ch,
  output logic [NUM_BITS-1:0]        err_data,
  input  logic                       err_ready,
  output logic                       busy
);

  // Handshake: a sample on channel i is consumed in the cycle where
  // meas_valid[i] && meas_ready[i]; an error is consumed in the cycle where
  // err_valid && err_ready. err_ch/err_data stay stable while err_valid waits.

  if (CH_W != clog2(NUM_CH)) begin : g_bad_ch_w
    $error("error_scheduler: CH_W must equal clog2(NUM_CH)");
  end

  logic [1:0]          state_q, state_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [CH_W-1:0]     tag_q, tag_d;
  logic                sub_en_q, sub_en_d;
  logic [NUM_BITS-1:0] sub_a_q, sub_a_d;
  logic [NUM_BITS-1:0] sub_b_q, sub_b_d;
  logic                err_valid_q, err_valid_d;
  logic [CH_W-1:0]     err_ch_q, err_ch_d;
  logic [NUM_BITS-1:0] err_data_q, err_data_d;
  logic [NUM_BITS-1:0] setpoint_q [NUM_CH];

  logic [NUM_CH-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;
  logic                arb_en;

  // Arbitration only happens in IDLE and never while reset is held.
  assign arb_en = (state_q == ST_IDLE) && !rst;

  error_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req_i        (meas_valid),
    .last_grant_i (last_grant_q),
    .en_i         (arb_en),
    .grant_o      (grant),
    .idx_o        (grant_idx)
  );

  assign meas_ready = grant;
  assign sub_en     = sub_en_q;
  assign sub_a      = sub_a_q;
  assign sub_b      = sub_b_q;
  assign err_valid  = err_valid_q;
  assign err_ch     = err_ch_q;
  assign err_data   = err_data_q;
  assign busy       = (state_q != ST_IDLE);

  // Next-state and datapath update for the grant/issue/wait/hold sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    sub_en_d     = sub_en_q;
    sub_a_d      = sub_a_q;
    sub_b_d      = sub_b_q;
    err_valid_d  = err_valid_q;
    err_ch_d     = err_ch_q;
    err_data_d   = err_data_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          // Setpoint is read before any same-cycle write lands, so the old value is issued.
          sub_a_d      = setpoint_q[grant_idx];
          sub_b_d      = meas_data[int'(grant_idx)*NUM_BITS +: NUM_BITS];
          sub_en_d     = 1'b1;
          tag_d        = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        sub_en_d = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (sub_valid) begin
          err_data_d  = sub_result;
          err_ch_d    = tag_q;
          err_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (err_ready) begin
          err_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and datapath registers; reset drops any in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      tag_q        <= '0;
      sub_en_q     <= 1'b0;
      sub_a_q      <= '0;
      sub_b_q      <= '0;
      err_valid_q  <= 1'b0;
      err_ch_q     <= '0;
      err_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      sub_en_q     <= sub_en_d;
      sub_a_q      <= sub_a_d;
      sub_b_q      <= sub_b_d;
      err_valid_q  <= err_valid_d;
      err_ch_q     <= err_ch_d;
      err_data_q   <= err_data_d;
    end
  end

  // Setpoint file: writable in every state, out-of-range indices dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) setpoint_q[i] <= '0;
    end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
      setpoint_q[cfg_ch] <= cfg_data;
    end
  end

endmodule
